// File: rtl/uart_tx_frame_fsm_if.sv
// Handshake and line signals between the UART transmit front end
// (parity_calculator plus whoever requests a word) and the frame serializer.
interface uart_tx_frame_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  parity_enable;
    logic                  parity_bit;
    logic                  serial_data;
    logic                  busy;

    // Requesting side: offers a word and its parity, watches the TX line
    modport master (
        output data_valid,
        output parallel_data,
        output parity_enable,
        output parity_bit,
        input  serial_data,
        input  busy
    );

    // Serializer side: consumes the request and drives the TX line
    modport slave (
        input  data_valid,
        input  parallel_data,
        input  parity_enable,
        input  parity_bit,
        output serial_data,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame_fsm.sv
// UART transmit frame controller: accepts a parallel word on a valid pulse
// and shifts out start bit, data bits LSB first, optional parity bit and
// STOP_BITS stop bits, one bit per clk cycle. The line idles high.
module uart_tx_frame_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input logic                clk,
    input logic                reset,
    uart_tx_frame_fsm_if.slave bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state_q,          state_d;
    logic [DATA_WIDTH-1:0] shift_q,          shift_d;
    logic [CNT_W-1:0]      bit_cnt_q,        bit_cnt_d;
    logic                  stop_cnt_q,       stop_cnt_d;
    logic                  parity_hold_q,    parity_hold_d;
    logic                  parity_en_hold_q, parity_en_hold_d;
    logic                  serial_q,         serial_d;
    logic                  busy_q,           busy_d;

    // Next-state logic: each branch decides the bit to present in the coming cycle
    always_comb begin
        state_d          = state_q;
        shift_d          = shift_q;
        bit_cnt_d        = bit_cnt_q;
        stop_cnt_d       = stop_cnt_q;
        parity_hold_d    = parity_hold_q;
        parity_en_hold_d = parity_en_hold_q;
        serial_d         = serial_q;
        busy_d           = busy_q;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (bus.data_valid && !busy_q) begin
                    shift_d          = bus.parallel_data;
                    parity_en_hold_d = bus.parity_enable;
                    busy_d           = 1'b1;
                    serial_d         = 1'b0;
                    state_d          = START;
                end
            end

            START: begin
                parity_hold_d = bus.parity_bit;
                serial_d      = shift_q[0];
                shift_d       = shift_q >> 1;
                bit_cnt_d     = '0;
                state_d       = DATA;
            end

            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (parity_en_hold_q) begin
                        serial_d = parity_hold_q;
                        state_d  = PARITY;
                    end else begin
                        serial_d   = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end else begin
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            PARITY: begin
                serial_d   = 1'b1;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end

            STOP: begin
                serial_d = 1'b1;
                if (stop_cnt_q == LAST_STOP) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end

            default: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame and returns the line high at once
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            shift_q          <= '0;
            bit_cnt_q        <= '0;
            stop_cnt_q       <= 1'b0;
            parity_hold_q    <= 1'b0;
            parity_en_hold_q <= 1'b0;
            serial_q         <= 1'b1;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            stop_cnt_q       <= stop_cnt_d;
            parity_hold_q    <= parity_hold_d;
            parity_en_hold_q <= parity_en_hold_d;
            serial_q         <= serial_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.serial_data = serial_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// Scoreboard bench for uart_tx_frame_fsm: one instance with a single stop bit
// and one with two. Each driven request pushes its expected per-cycle
// {serial_data, busy} pairs; a monitor per instance pops and compares them.
module tb_uart_tx_frame_fsm;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset1;
    logic reset2;

    always #5 clk = ~clk;

    uart_tx_frame_fsm_if #(.DATA_WIDTH(DW)) bus1 ();
    uart_tx_frame_fsm_if #(.DATA_WIDTH(DW)) bus2 ();

    uart_tx_frame_fsm #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    uart_tx_frame_fsm #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q1[$];
    logic [1:0] exp_q2[$];
    int         cyc1 = 0;
    int         cyc2 = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h required=%0h", tag, got, want);
        end
    endtask

    // Monitor for the single-stop-bit instance
    always @(negedge clk) begin
        logic [1:0] e;
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checkOutput($sformatf("dut1 {serial,busy} item%0d", cyc1),
                        {30'd0, bus1.serial_data, bus1.busy}, {30'd0, e});
            cyc1++;
        end
    end

    // Monitor for the two-stop-bit instance
    always @(negedge clk) begin
        logic [1:0] e;
        if (exp_q2.size() > 0) begin
            e = exp_q2.pop_front();
            checkOutput($sformatf("dut2 {serial,busy} item%0d", cyc2),
                        {30'd0, bus2.serial_data, bus2.busy}, {30'd0, e});
            cyc2++;
        end
    end

    task automatic push_item(input int sel, input logic [1:0] v);
        if (sel == 1) exp_q1.push_back(v);
        else          exp_q2.push_back(v);
    endtask

    function automatic int q_size(input int sel);
        return (sel == 1) ? exp_q1.size() : exp_q2.size();
    endfunction

    // Expected frame: start, data LSB first, optional parity, stop bits, busy high throughout
    task automatic push_frame(input int sel, input logic [DW-1:0] d, input logic pe,
                              input logic pb, input int stops);
        push_item(sel, 2'b01);
        for (int i = 0; i < DW; i++) push_item(sel, {d[i], 1'b1});
        if (pe) push_item(sel, {pb, 1'b1});
        for (int i = 0; i < stops; i++) push_item(sel, 2'b11);
    endtask

    task automatic drive_in(input int sel, input logic dv, input logic [DW-1:0] d, input logic pe);
        if (sel == 1) begin
            bus1.data_valid    = dv;
            bus1.parallel_data = d;
            bus1.parity_enable = pe;
        end else begin
            bus2.data_valid    = dv;
            bus2.parallel_data = d;
            bus2.parity_enable = pe;
        end
    endtask

    task automatic set_parity(input int sel, input logic pb);
        if (sel == 1) bus1.parity_bit = pb;
        else          bus2.parity_bit = pb;
    endtask

    task automatic set_reset(input int sel, input logic r);
        if (sel == 1) reset1 = r;
        else          reset2 = r;
    endtask

    task automatic wait_drain(input int sel);
        int n;
        n = 0;
        while (q_size(sel) > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("dut%0d scoreboard drained", sel), q_size(sel), 0);
    endtask

    // One request pulse; the parity source registers its result at the accepting edge
    task automatic applyStimulus(input int sel, input logic [DW-1:0] d, input logic pe,
                                 input logic ptype, input int stops);
        logic pb;
        pb = (^d) ^ ptype;
        @(negedge clk);
        drive_in(sel, 1'b1, d, pe);
        @(posedge clk);
        set_parity(sel, pb);
        push_frame(sel, d, pe, pb, stops);
        push_item(sel, 2'b10);
        @(negedge clk);
        drive_in(sel, 1'b0, '0, 1'b0);
        wait_drain(sel);
    endtask

    // Abort on data bit 4 with a colliding request, then send 8'h55 cleanly
    task automatic reset_mid_frame(input int sel, input int stops);
        logic [DW-1:0] d;
        d = 8'hA5;
        @(negedge clk);
        drive_in(sel, 1'b1, d, 1'b0);
        @(posedge clk);
        push_item(sel, 2'b01);
        for (int i = 0; i < 5; i++) push_item(sel, {d[i], 1'b1});
        for (int i = 0; i < 3; i++) push_item(sel, 2'b10);
        @(negedge clk);
        drive_in(sel, 1'b0, '0, 1'b0);
        repeat (5) @(negedge clk);
        set_reset(sel, 1'b1);
        drive_in(sel, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        set_reset(sel, 1'b0);
        drive_in(sel, 1'b0, '0, 1'b0);
        wait_drain(sel);
        applyStimulus(sel, 8'h55, 1'b0, 1'b0, stops);
        applyStimulus(sel, 8'h55, 1'b1, 1'b0, stops);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset1 = 1'b1;
        reset2 = 1'b1;
        drive_in(1, 1'b0, '0, 1'b0);
        drive_in(2, 1'b0, '0, 1'b0);
        set_parity(1, 1'b0);
        set_parity(2, 1'b0);

        repeat (2) @(posedge clk);
        push_item(1, 2'b10);
        push_item(2, 2'b10);
        @(negedge clk);
        reset1 = 1'b0;
        reset2 = 1'b0;
        push_item(1, 2'b10);
        push_item(2, 2'b10);
        wait_drain(1);
        wait_drain(2);

        $display("[TB] single frames, parity off/even/odd");
        applyStimulus(1, 8'hA5, 1'b0, 1'b0, 1);
        applyStimulus(1, 8'hA5, 1'b1, 1'b0, 1);
        applyStimulus(1, 8'hA5, 1'b1, 1'b1, 1);
        applyStimulus(1, 8'h00, 1'b1, 1'b0, 1);
        applyStimulus(1, 8'hFF, 1'b1, 1'b0, 1);

        $display("[TB] back-to-back frames with data_valid held");
        @(negedge clk);
        drive_in(1, 1'b1, 8'h3C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            push_frame(1, 8'h3C, 1'b0, 1'b0, 1);
            push_item(1, 2'b10);
            if (k == 2) begin
                push_item(1, 2'b10);
                push_item(1, 2'b10);
                @(negedge clk);
                drive_in(1, 1'b0, '0, 1'b0);
            end else begin
                repeat (10) @(posedge clk);
            end
        end
        wait_drain(1);

        $display("[TB] request and parity changes during a frame");
        @(negedge clk);
        drive_in(1, 1'b1, 8'h0F, 1'b1);
        @(posedge clk);
        set_parity(1, 1'b0);
        push_frame(1, 8'h0F, 1'b1, 1'b0, 1);
        for (int i = 0; i < 4; i++) push_item(1, 2'b10);
        @(negedge clk);
        drive_in(1, 1'b0, '0, 1'b0);
        repeat (4) @(negedge clk);
        drive_in(1, 1'b1, 8'hFF, 1'b0);
        set_parity(1, 1'b1);
        @(negedge clk);
        drive_in(1, 1'b0, 8'h00, 1'b1);
        wait_drain(1);

        $display("[TB] reset during data, one and two stop bits");
        reset_mid_frame(1, 1);
        reset_mid_frame(2, 2);
        applyStimulus(2, 8'hA5, 1'b1, 1'b1, 2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
